// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath, food placement and renderer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package snake_pkg;

    // Game state encoding driven by the game controller.
    localparam logic [1:0] RUNNING = 2'b00;
    localparam logic [1:0] DIE     = 2'b01;
    localparam logic [1:0] INITIAL = 2'b10;

    // Snake direction encoding.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Grid geometry: 5-bit coordinates; row/column 0 and the outer edge are wall.
    localparam int         COORD_W    = 5;
    localparam logic [4:0] GRID_X_MIN = 5'd1;
    localparam logic [4:0] GRID_X_MAX = 5'd30;
    localparam logic [4:0] GRID_Y_MIN = 5'd1;
    localparam logic [4:0] GRID_Y_MAX = 5'd22;

    // Food position shown after reset or a new game.
    localparam logic [4:0] FOOD_INIT_X = 5'd20;
    localparam logic [4:0] FOOD_INIT_Y = 5'd9;

    // Food LFSR start value; any nonzero value keeps the LFSR out of the lock-up state.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Food placement search states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_PLACE = 2'd3
    } fg_state_t;

    function automatic logic in_range(input logic [4:0] c,
                                      input logic [4:0] lo,
                                      input logic [4:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/food_if.sv
// Bundle between the snake datapath (master) and the food placement engine (slave).
// Latency: n/a (wires only).
// Backpressure: none; get_food is a level, busy/food_valid report progress.
// Ports: game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length toward the engine;
//        food_x, food_y, food_valid, busy back from it.
interface food_if #(
    parameter int MAX_LEN = 64
);
    localparam int LEN_W = $clog2(MAX_LEN);

    logic [1:0]           game_state;
    logic                 get_food;
    logic [MAX_LEN*5-1:0] snake_x_1dim;
    logic [MAX_LEN*5-1:0] snake_y_1dim;
    logic [LEN_W-1:0]     snake_length;
    logic [4:0]           food_x;
    logic [4:0]           food_y;
    logic                 food_valid;
    logic                 busy;

    modport master (
        output game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
        input  food_x, food_y, food_valid, busy
    );

    modport slave (
        input  game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
        output food_x, food_y, food_valid, busy
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shift-left, taps 15/13/12/10 fed into bit 0.
// Latency: q updates one cycle after en or load.
// Backpressure: none; holds value while en is low.
// Ports: clk, rst_n (sync, active-low), load (forces SEED), en (advance), q.
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/food_gen.sv
// Food placement engine: draws LFSR candidates, rejects off-field or body cells, places food.
// Latency: 3 + len cycles from a get_food rising edge when the first candidate is accepted.
// Backpressure: get_food edges while busy are ignored; DIE freezes the whole search.
// Ports: clk, rst_n (sync, active-low), fif (food_if.slave: game state, body vectors,
//        get_food in; food_x/food_y/food_valid/busy out).
module food_gen
    import snake_pkg::*;
#(
    parameter int          MAX_LEN = 64,
    parameter logic [4:0]  X_MIN   = GRID_X_MIN,
    parameter logic [4:0]  X_MAX   = GRID_X_MAX,
    parameter logic [4:0]  Y_MIN   = GRID_Y_MIN,
    parameter logic [4:0]  Y_MAX   = GRID_Y_MAX,
    parameter logic [4:0]  INIT_X  = FOOD_INIT_X,
    parameter logic [4:0]  INIT_Y  = FOOD_INIT_Y,
    parameter logic [15:0] SEED    = LFSR_SEED
) (
    input  logic  clk,
    input  logic  rst_n,
    food_if.slave fif
);

    localparam int IDX_W = $clog2(MAX_LEN);

    fg_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [4:0]       cand_x_q, cand_x_d;
    logic [4:0]       cand_y_q, cand_y_d;
    logic [4:0]       food_x_q, food_x_d;
    logic [4:0]       food_y_q, food_y_d;
    logic             food_valid_q, food_valid_d;
    logic             get_food_q;

    logic [15:0]      lfsr_q;
    logic             lfsr_en;
    logic [4:0]       draw_x;
    logic [4:0]       draw_y;
    logic [4:0]       seg_x;
    logic [4:0]       seg_y;
    logic             run;
    logic             init;
    logic             food_rise;
    logic             unused_lfsr_bits;

    assign run       = (fif.game_state == RUNNING);
    assign init      = (fif.game_state == INITIAL);
    assign food_rise = fif.get_food && !get_food_q;

    // Candidate fields straight from the LFSR; the remaining bits only feed the shift.
    assign draw_x           = lfsr_q[4:0];
    assign draw_y           = lfsr_q[12:8];
    assign unused_lfsr_bits = ^{lfsr_q[15:13], lfsr_q[7:5]};

    assign seg_x = fif.snake_x_1dim[idx_q*COORD_W +: COORD_W];
    assign seg_y = fif.snake_y_1dim[idx_q*COORD_W +: COORD_W];

    // The LFSR only moves on DRAW cycles, so candidate order is reproducible from reset.
    assign lfsr_en = run && (state_q == ST_DRAW);

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (init),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;

        // Anything other than RUNNING (DIE) holds every register in place.
        if (run) begin
            case (state_q)
                ST_IDLE: begin
                    if (food_rise) begin
                        state_d      = ST_DRAW;
                        // A zero length still scans segment 0 (the head).
                        len_d        = (fif.snake_length == '0) ? IDX_W'(1) : fif.snake_length;
                        // (0,0) is a wall cell, so the renderer never shows stale food here.
                        food_valid_d = 1'b0;
                        food_x_d     = '0;
                        food_y_d     = '0;
                    end
                end
                ST_DRAW: begin
                    if (in_range(draw_x, X_MIN, X_MAX) && in_range(draw_y, Y_MIN, Y_MAX)) begin
                        cand_x_d = draw_x;
                        cand_y_d = draw_y;
                        idx_d    = '0;
                        state_d  = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if ((seg_x == cand_x_q) && (seg_y == cand_y_q)) begin
                        state_d = ST_DRAW;
                    end else if (idx_q == len_q - IDX_W'(1)) begin
                        state_d = ST_PLACE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_PLACE: begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= IDX_W'(1);
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= INIT_X;
            food_y_q     <= INIT_Y;
            food_valid_q <= 1'b1;
            get_food_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            get_food_q   <= fif.get_food;
        end
    end

    assign fif.food_x     = food_x_q;
    assign fif.food_y     = food_y_q;
    assign fif.food_valid = food_valid_q;
    assign fif.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/food_gen.md
# food_gen

Food placement engine for the snake game. It consumes the `get_food` strobe and snake body vectors produced by the snake movement logic, and returns a new `food_x`/`food_y` target on the grid. Every candidate comes from a 16-bit LFSR and is rejected if it lies outside the playfield or under any body segment. The block sits beside the snake datapath and feeds both that datapath and the VGA renderer.

## Interface
- `MAX_LEN`, 64: body array depth; 5-bit coordinates per segment.
- `X_MIN`/`X_MAX`, 1/30: legal food column range, inclusive.
- `Y_MIN`/`Y_MAX`, 1/22: legal food row range, inclusive.
- `INIT_X`/`INIT_Y`, 20/9: food position after reset or INITIAL.
- `SEED`, 16'hACE1: LFSR value after reset or INITIAL. Must be nonzero.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `game_state`  in  2  RUNNING=00, DIE=01, INITIAL=10.
- `get_food`  in  1  level; high while the snake head sits on food.
- `snake_x_1dim`, `snake_y_1dim`  in  320 each  segment i at bits `[i*5+:5]`.
- `snake_length`  in  6  number of valid segments.
- `food_x`, `food_y`  out  5 each  current food cell.
- `food_valid`  out  1  food placed and displayable.
- `busy`  out  1  search in progress.

## Operation
- States: IDLE, DRAW, SCAN, PLACE.
- The LFSR is Fibonacci type, shift-left.
  - Feedback = b15^b13^b12^b10, inserted at bit 0.
  - It advances only in DRAW cycles, so candidate order is deterministic from reset.
- IDLE:
  - A rising edge of `get_food` (registered previous value) while `game_state`==RUNNING moves to DRAW.
  - On that edge, latch `len` = max(`snake_length`, 1).
  - On that edge, drive `food_valid`=0 and `food_x`=`food_y`=0. Cell (0,0) is a wall cell and is unreachable while alive.
- DRAW:
  - Candidate is cx = lfsr[4:0], cy = lfsr[12:8].
  - If cx or cy is out of range, stay in DRAW.
  - Otherwise register the candidate, set idx=0 and go to SCAN.
  - Step the LFSR every DRAW cycle.
- SCAN:
  - Compare the candidate against segment idx, one segment per cycle.
  - On a match, go to DRAW.
  - On no match with idx==len-1, go to PLACE.
  - Otherwise idx+1.
- PLACE: write the candidate to `food_x`/`food_y`, set `food_valid`=1, go to IDLE.
- `busy` = (state != IDLE).
- DIE: the FSM, LFSR and outputs freeze in their current state and values.
- INITIAL or `rst_n`=0 (either one, at any state, including mid-search):
  - state=IDLE, lfsr=SEED, food=(INIT_X,INIT_Y), `food_valid`=1.
  - Edge register cleared.
- A `get_food` edge while busy is ignored. It cannot occur in normal play because move ticks are millions of cycles apart.
- Termination is guaranteed: the grid has 660 cells and the snake at most 64 segments, and the LFSR period is 65535.

## Timing
- Reset values: `food_x`=20, `food_y`=9, `food_valid`=1, `busy`=0.
- Rising `get_food` sampled at edge E0:
  - `food_valid` goes 0 and `busy` goes 1 after E0.
  - DRAW at E1.
  - For a first candidate that is accepted: SCAN E2..E(1+len), PLACE at E(2+len).
  - `food_valid`=1 and `busy`=0 after E(2+len).
- Each rejected candidate adds 1 cycle for a range reject, or (idx+2) cycles for a body hit at segment idx.
- Worst-case search is well below one move period at the fastest speed.

## Structure
- Shared package `snake_pkg` holds:
  - game-state constants RUNNING/DIE/INITIAL;
  - direction constants;
  - grid bounds;
  - `SEED`.
- Sub-module `lfsr16` provides ports `clk`, `rst_n`, `load`, `en`, `q[15:0]`. `load` forces SEED.
- The FSM, scan counter and output registers live in `food_gen`.

## Test plan
- Reset, then release -> food=(20,9), `food_valid`=1, `busy`=0; LFSR=16'hACE1.
- RUNNING, len=3, body (15,9),(15,10),(15,11), `get_food` rising -> sequence:
  - candidate (1,12) accepted;
  - PLACE at E5;
  - food=(1,12), `food_valid`=1 after E5.
- Same stimulus with segment 1 = (1,12) -> required response:
  - (1,12) rejected at the idx=1 compare;
  - (3,25) range-rejected;
  - (7,19) scanned and placed.
- `get_food` held high for 1000 cycles -> exactly one search; `food_valid` stays 1 afterwards.
- `game_state`=DIE mid-SCAN -> state, idx and outputs frozen. On return to RUNNING, the search resumes and completes.
- `rst_n` low for one cycle mid-SCAN, or `game_state`=INITIAL mid-SCAN -> next cycle:
  - food=(20,9), `food_valid`=1, `busy`=0;
  - the next search again begins from candidate (1,12).
